decode_exec_core: RTL and testbench

//  Single-cycle integer datapath: instruction decoder, 8x32 register file and ALU in one block.

---
 rtl/decode_exec_core.sv | 89 ++++++++
 tb/tb_decode_exec_core.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/decode_exec_core.sv
// Single-cycle integer datapath: instruction decode, 8x32 register file and ALU.
// Result and write_enable are combinational; the register file updates on the next rising clk.
module decode_exec_core #(
    parameter int unsigned NREGS = 8,
    parameter int unsigned DW    = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [31:0]   instruction,
    input  logic          instr_valid,
    input  logic [2:0]    dbg_addr,
    output logic [DW-1:0] dbg_data,
    output logic [DW-1:0] result,
    output logic          write_enable,
    output logic [2:0]    write_addr
);

    localparam int unsigned RW = 3;
    localparam int unsigned SW = 5;

    typedef struct packed {
        logic          rsvd;
        logic          ir_op;
        logic          alu_cls;
        logic [3:0]    opcode;
        logic [RW-1:0] rd;
        logic [RW-1:0] rn;
        logic [RW-1:0] rm;
        logic [15:0]   imm16;
    } instr_t;

    instr_t        f;
    logic [DW-1:0] regs [NREGS];
    logic [DW-1:0] op1;
    logic [DW-1:0] op2;
    logic [DW-1:0] rd_val;
    logic [SW-1:0] shamt;
    logic          legal;

    assign f          = instr_t'(instruction);
    assign op1        = regs[f.rn];
    assign rd_val     = regs[f.rd];
    assign op2        = f.ir_op ? regs[f.rm] : DW'(f.imm16);
    assign shamt      = op2[SW-1:0];
    assign dbg_data   = regs[dbg_addr];
    assign write_addr = f.rd;

    // Reserved bit and reset both suppress commit; result is still decoded for observation.
    assign write_enable = instr_valid & legal & ~f.rsvd & ~rst;

    // Decode and execute
    always_comb begin
        legal  = 1'b0;
        result = '0;
        if (!f.alu_cls) begin
            case (f.opcode)
                4'b0000: begin result = DW'(f.imm16);                       legal = 1'b1; end
                4'b0001: begin result = DW'({f.imm16, rd_val[15:0]});       legal = 1'b1; end
                4'b0010: begin result = '0;                                  legal = 1'b1; end
                4'b0011: begin result = '1;                                  legal = 1'b1; end
                default: begin result = '0;                                  legal = 1'b0; end
            endcase
        end else begin
            case (f.opcode)
                4'b0001: begin result = op1 + op2;                           legal = 1'b1; end
                4'b0010: begin result = op1 - op2;                           legal = 1'b1; end
                4'b0011: begin result = op1 & op2;                           legal = 1'b1; end
                4'b0100: begin result = op1 | op2;                           legal = 1'b1; end
                4'b0101: begin result = op1 ^ op2;                           legal = 1'b1; end
                4'b0110: begin result = op1 << shamt;                        legal = 1'b1; end
                4'b0111: begin result = op1 >> shamt;                        legal = 1'b1; end
                4'b1000: begin result = DW'($signed(op1) >>> shamt);         legal = 1'b1; end
                default: begin result = '0;                                  legal = 1'b0; end
            endcase
        end
    end

    // Register file: reset wins over a simultaneous write; no read bypass.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++) begin
                regs[i] <= '0;
            end
        end else if (write_enable) begin
            regs[f.rd] <= result;
        end
    end

endmodule

// File: tb/tb_decode_exec_core.sv
// Table-driven bench for decode_exec_core with a scoreboard of post-edge register expectations.
module tb_decode_exec_core;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] instruction;
    logic        instr_valid;
    logic [2:0]  dbg_addr;
    logic [31:0] dbg_data;
    logic [31:0] result;
    logic        write_enable;
    logic [2:0]  write_addr;

    decode_exec_core dut (
        .clk          (clk),
        .rst          (rst),
        .instruction  (instruction),
        .instr_valid  (instr_valid),
        .dbg_addr     (dbg_addr),
        .dbg_data     (dbg_data),
        .result       (result),
        .write_enable (write_enable),
        .write_addr   (write_addr)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] instr;
        logic        valid;
        logic        exp_we;
        logic        chk_res;
        logic [31:0] exp_res;
        logic [2:0]  ra;
        logic [31:0] va;
        logic [2:0]  rb;
        logic [31:0] vb;
    } vec_t;

    typedef struct {
        logic [2:0]  ra;
        logic [31:0] va;
        logic [2:0]  rb;
        logic [31:0] vb;
    } sb_t;

    vec_t vecs[$];
    sb_t  sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic void addv(input logic [31:0] i, input logic val, input logic we,
                                 input logic cr, input logic [31:0] res,
                                 input logic [2:0] ra, input logic [31:0] va,
                                 input logic [2:0] rb, input logic [31:0] vb);
        vec_t v;
        v = '{i, val, we, cr, res, ra, va, rb, vb};
        vecs.push_back(v);
    endfunction

    task automatic read_reg(input logic [2:0] r, output logic [31:0] d);
        dbg_addr = r;
        #1;
        d = dbg_data;
    endtask

    task automatic apply(input vec_t v);
        sb_t         e;
        logic [31:0] d;
        logic [2:0]  wa;
        @(negedge clk);
        instruction = v.instr;
        instr_valid = v.valid;
        #1;
        wa = v.instr[24:22];
        check($sformatf("we[%h]", v.instr), 32'(write_enable), 32'(v.exp_we));
        if (v.exp_we) check($sformatf("waddr[%h]", v.instr), 32'(write_addr), 32'(wa));
        if (v.chk_res) check($sformatf("result[%h]", v.instr), result, v.exp_res);
        e = '{v.ra, v.va, v.rb, v.vb};
        sb.push_back(e);
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL scoreboard: got empty queue expected entry");
        end else begin
            e = sb.pop_front();
            read_reg(e.ra, d);
            check($sformatf("R%0d after %h", e.ra, v.instr), d, e.va);
            read_reg(e.rb, d);
            check($sformatf("R%0d after %h", e.rb, v.instr), d, e.vb);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        logic [31:0] d;
        vec_t        v;

        // Stimulus table: instr, valid, we, chk_res, result, regA, valA, regB, valB
        addv(32'h0000_FFFF, 1, 1, 1, 32'h0000_FFFF, 0, 32'h0000_FFFF, 1, 32'h0);
        addv(32'h0200_EEEE, 1, 1, 1, 32'hEEEE_FFFF, 0, 32'hEEEE_FFFF, 1, 32'h0);
        addv(32'h0640_0000, 1, 1, 1, 32'hFFFF_FFFF, 1, 32'hFFFF_FFFF, 0, 32'hEEEE_FFFF);
        addv(32'h0480_0000, 1, 1, 1, 32'h0000_0000, 2, 32'h0,         1, 32'hFFFF_FFFF);
        for (int r = 0; r < 8; r++)
            addv(32'h0600_0000 + (32'(r) << 22), 1, 1, 1, 32'hFFFF_FFFF,
                 3'(r), 32'hFFFF_FFFF, (r == 0) ? 3'd1 : 3'd0, 32'hFFFF_FFFF);
        for (int r = 0; r < 8; r++)
            addv(32'h0400_0000 + (32'(r) << 22), 1, 1, 1, 32'h0,
                 3'(r), 32'h0, 3'((r + 1) % 8), (r == 7) ? 32'h0 : 32'hFFFF_FFFF);
        addv(32'h0040_0001, 1, 1, 1, 32'h0000_0001, 1, 32'h1,         0, 32'h0);
        addv(32'h2200_0001, 1, 1, 1, 32'h0000_0001, 0, 32'h1,         1, 32'h1);
        addv(32'h6201_0000, 1, 1, 1, 32'h0000_0002, 0, 32'h2,         1, 32'h1);
        addv(32'h00C0_0000, 1, 1, 1, 32'h0000_0000, 3, 32'h0,         0, 32'h2);
        addv(32'h24D8_0001, 1, 1, 1, 32'hFFFF_FFFF, 3, 32'hFFFF_FFFF, 0, 32'h2);
        addv(32'h2D18_0004, 1, 1, 1, 32'hFFFF_FFF0, 4, 32'hFFFF_FFF0, 3, 32'hFFFF_FFFF);
        addv(32'h2F60_0004, 1, 1, 1, 32'h0FFF_FFFF, 5, 32'h0FFF_FFFF, 4, 32'hFFFF_FFF0);
        addv(32'h31A0_0004, 1, 1, 1, 32'hFFFF_FFFF, 6, 32'hFFFF_FFFF, 4, 32'hFFFF_FFF0);
        addv(32'h27E0_1234, 1, 1, 1, 32'h0000_1230, 7, 32'h0000_1230, 6, 32'hFFFF_FFFF);
        addv(32'h29F8_000F, 1, 1, 1, 32'h0000_123F, 7, 32'h0000_123F, 5, 32'h0FFF_FFFF);
        addv(32'h6BFD_0000, 1, 1, 1, 32'h0FFF_EDC0, 7, 32'h0FFF_EDC0, 5, 32'h0FFF_FFFF);
        addv(32'h64AB_0000, 1, 1, 1, 32'h1000_0000, 2, 32'h1000_0000, 3, 32'hFFFF_FFFF);
        addv(32'h2080_0000, 1, 0, 0, 32'h0,         2, 32'h1000_0000, 7, 32'h0FFF_EDC0);
        addv(32'h0880_0000, 1, 0, 0, 32'h0,         2, 32'h1000_0000, 7, 32'h0FFF_EDC0);
        addv(32'h3280_0000, 1, 0, 0, 32'h0,         2, 32'h1000_0000, 7, 32'h0FFF_EDC0);
        addv(32'h8680_0000, 1, 0, 0, 32'h0,         2, 32'h1000_0000, 1, 32'h1);
        addv(32'h4080_0055, 1, 1, 1, 32'h0000_0055, 2, 32'h0000_0055, 1, 32'h1);
        addv(32'h2C48_0021, 1, 1, 1, 32'h0000_0002, 1, 32'h2,         2, 32'h0000_0055);
        addv(32'h62D9_0000, 1, 1, 1, 32'h0000_0001, 3, 32'h1,         1, 32'h2);
        addv(32'h0580_0000, 0, 0, 0, 32'h0,         6, 32'hFFFF_FFFF, 3, 32'h1);

        rst         = 1'b1;
        instruction = 32'h0;
        instr_valid = 1'b0;
        dbg_addr    = 3'd0;
        repeat (2) @(posedge clk);
        #1;
        check("we during reset", 32'(write_enable), 32'h0);
        for (int r = 0; r < 8; r++) begin
            read_reg(3'(r), d);
            check($sformatf("reset R%0d", r), d, 32'h0);
        end
        @(negedge clk);
        rst = 1'b0;

        foreach (vecs[i]) apply(vecs[i]);

        // Read-during-write: old R0 visible until the edge
        @(negedge clk);
        instruction = 32'h0000_00AB;
        instr_valid = 1'b1;
        dbg_addr    = 3'd0;
        #1;
        check("rdw old R0", dbg_data, 32'h2);
        check("rdw result", result, 32'h0000_00AB);
        @(posedge clk);
        #1;
        read_reg(3'd0, d);
        check("rdw new R0", d, 32'h0000_00AB);

        // Unknown instruction with instr_valid low must not write
        @(negedge clk);
        instruction = 'x;
        instr_valid = 1'b0;
        #1;
        check("we x-instr", 32'(write_enable), 32'h0);
        @(posedge clk);
        #1;
        read_reg(3'd0, d);
        check("x-instr R0", d, 32'h0000_00AB);
        read_reg(3'd7, d);
        check("x-instr R7", d, 32'h0FFF_EDC0);

        // Bubble SET R6 leaves R6 alone
        v = '{32'h0180_0007, 1, 1, 1, 32'h7, 6, 32'h7, 0, 32'h0000_00AB};
        apply(v);
        v = '{32'h0780_0000, 0, 0, 0, 32'h0, 6, 32'h7, 5, 32'h0FFF_FFFF};
        apply(v);

        // Reset together with a valid SET R5: reset wins
        @(negedge clk);
        rst         = 1'b1;
        instruction = 32'h0740_0000;
        instr_valid = 1'b1;
        #1;
        check("we with rst", 32'(write_enable), 32'h0);
        check("result with rst", result, 32'hFFFF_FFFF);
        @(posedge clk);
        #1;
        for (int r = 0; r < 8; r++) begin
            read_reg(3'(r), d);
            check($sformatf("mid-reset R%0d", r), d, 32'h0);
        end
        @(negedge clk);
        rst = 1'b0;
        v = '{32'h0140_0001, 1, 1, 1, 32'h1, 5, 32'h1, 6, 32'h0};
        apply(v);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
